adc_capture_seq: RTL and testbench
==================================

# adc_capture_seq

Triggered capture sequencer that writes a run of ADC samples into a to-host BRAM write port. It sits in the DSP clock domain between the cross-domain ADC sample word and the to-host BRAM write port (addr/data/we). It is armed by the host, waits for a trigger, applies a programmable post-trigger delay and decimation, and writes exactly `length` words from address 0 upward. It then flags completion for host readout.

## Interface

Parameters:
- `ADDRWIDTH`, 13: BRAM word-address width.
- `DATAWIDTH`, 64: sample/BRAM word width.
- `DELAYWIDTH`, 16: post-trigger delay counter width.
- `DECIMWIDTH`, 8: decimation factor width.

Ports:
- `clk`, in, 1: DSP clock; the only clock.
- `reset`, in, 1: synchronous, active-high.
- `arm`, in, 1: single-cycle pulse; latches configuration and starts the sequence.
- `abort`, in, 1: single-cycle pulse; returns to IDLE from any state.
- `trig`, in, 1: trigger pulse; level-sampled each cycle.
- `delay`, in, DELAYWIDTH: post-trigger delay in clk cycles; latched on arm.
- `decim`, in, DECIMWIDTH: keep 1 of every decim+1 valid samples; latched on arm.
- `length`, in, ADDRWIDTH+1: number of words to write; latched on arm.
- `din`, in, DATAWIDTH: ADC sample word.
- `din_valid`, in, 1: `din` qualifier.
- `bram_addr`, out, ADDRWIDTH: word address, registered.
- `bram_data`, out, DATAWIDTH: write data, registered.
- `bram_we`, out, 1: write enable, registered.
- `busy`, out, 1: high in ARMED, DELAY and CAPTURE.
- `done`, out, 1: capture complete; sticky.
- `wrcount`, out, ADDRWIDTH+1: words written in the current/last run.

## Operation

- States are IDLE, ARMED, DELAY, CAPTURE and DONE.
- Reset forces state to IDLE. All outputs are 0 after reset (`bram_addr`, `bram_data`, `bram_we`, `busy`, `done`, `wrcount`).
- Configuration (`delay`, `decim`, `length`) is latched only on an accepted `arm`. Input changes at any other time have no effect on a run.
- `length` latched value is clamped to 2^ADDRWIDTH. `length`=0 sends IDLE/DONE directly to DONE on `arm`, with no writes.
- IDLE or DONE, `arm`=1: clear `done`, clear `wrcount`, clear the address pointer and decimation counter, go to ARMED.
- `arm` is ignored in ARMED, DELAY and CAPTURE.
- ARMED, `trig`=1: with latched delay=0 go to CAPTURE; otherwise load the delay counter with `delay` and go to DELAY.
  - A `trig` in the same cycle as the accepted `arm` is ignored (state is still IDLE/DONE in that cycle).
- DELAY: decrement the counter every cycle and go to CAPTURE in the cycle the counter equals 1.
- `trig` outside ARMED is ignored; re-triggers are not queued.
- CAPTURE: each cycle with `din_valid`=1, test the decimation counter.
  - Counter = 0: accept the sample.
  - Counter then increments, wrapping from the latched `decim` back to 0.
  - The first valid sample in CAPTURE is always accepted.
  - `din_valid`=0 cycles neither advance the decimation counter nor write.
- On an accepted sample: register `bram_we`=1, `bram_data`=`din`, `bram_addr`=pointer; then pointer+1 and `wrcount`+1.
- When the accepted sample is the length-th, go to DONE.
- DONE: `done`=1 held until the next accepted `arm`, `abort` or `reset`. `wrcount` is held.
- `abort` in any state: go to IDLE, `done`=0, `bram_we`=0 from the next cycle, `wrcount` held.
  - `abort` takes priority over `arm`, `trig` and any write in the same cycle; that sample is not written.
- Pointer never wraps within a run, because length ≤ 2^ADDRWIDTH. A full-depth run ends at address 2^ADDRWIDTH−1.

## Timing

- Write latency is 1: a sample accepted in cycle c appears as `bram_we`=1 with its `bram_addr`/`bram_data` in cycle c+1.
- `bram_we` is a one-cycle pulse per accepted sample. Back-to-back writes occur when `din_valid` is continuous and decim=0.
- Trigger to CAPTURE: `trig` in cycle t gives state CAPTURE in cycle t+1+delay. The earliest sample accepted is in cycle t+1+delay; its write appears in t+2+delay.
- `done` rises in the same cycle as the last `bram_we` pulse. `busy` falls in that same cycle.
- `busy` rises the cycle after the accepted `arm`.
- `wrcount` updates in the same cycle as the corresponding `bram_we`.
- Outputs hold their last value while `bram_we`=0, except `bram_we` itself.

## Test plan

- **Basic capture.** Apply `arm` with length=4, delay=0, decim=0, `din_valid`=1, `din` = cycle counter; then `trig` at cycle t. Required: writes at addresses 0..3 in cycles t+2..t+5 with `din` values from t+1..t+4; `done`=1 at t+5; `wrcount`=4.
- **Delay and decimation.** Apply delay=3, decim=2, length=3, continuous valid. Required: the first write carries the sample from t+4, followed by samples t+7 and t+10; addresses 0, 1, 2.
- **Gapped valid.** Apply length=2, decim=0, with `din_valid` toggling 1,0,0,1. Required: exactly 2 writes of the two valid samples; no write on the invalid cycles.
- **Boundary cases.**
  - length=0 with `arm`: `done`=1 next cycle, no `bram_we`.
  - length=2^ADDRWIDTH+1: clamped; the final write is at address 2^ADDRWIDTH−1 and `wrcount`=2^ADDRWIDTH.
- **Abort and ignored pulses.**
  - `abort` mid-CAPTURE after 2 writes: state IDLE, `done`=0, `wrcount`=2, no further `bram_we`.
  - `arm` during CAPTURE: ignored.
  - `trig` coincident with `arm`: not a trigger.
- **Reset mid-run.** Assert `reset` during DELAY. Required: all outputs 0 the next cycle; a later `trig` without `arm` produces no writes.

Source files
------------

// File: rtl/adc_capture_seq.sv
// Triggered ADC capture sequencer: armed by the host, waits for a trigger,
// applies a post-trigger delay and decimation, then writes `length` samples
// into a BRAM write port from address 0 upward and flags completion.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for arm
// ARMED   | configuration latched, waiting for trig
// DELAY   | counting down the post-trigger delay
// CAPTURE | accepting decimated valid samples and writing them to BRAM
// DONE    | run complete, done held until the next arm/abort/reset
module adc_capture_seq #(
    parameter int ADDRWIDTH  = 13,
    parameter int DATAWIDTH  = 64,
    parameter int DELAYWIDTH = 16,
    parameter int DECIMWIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  arm,
    input  logic                  abort,
    input  logic                  trig,
    input  logic [DELAYWIDTH-1:0] delay,
    input  logic [DECIMWIDTH-1:0] decim,
    input  logic [ADDRWIDTH:0]    length,
    input  logic [DATAWIDTH-1:0]  din,
    input  logic                  din_valid,
    output logic [ADDRWIDTH-1:0]  bram_addr,
    output logic [DATAWIDTH-1:0]  bram_data,
    output logic                  bram_we,
    output logic                  busy,
    output logic                  done,
    output logic [ADDRWIDTH:0]    wrcount
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_CAPTURE,
        S_DONE
    } state_t;

    // Full BRAM depth; a longer requested run is cut to this so the
    // address pointer can never wrap inside a run.
    localparam logic [ADDRWIDTH:0] DEPTH = {1'b1, {ADDRWIDTH{1'b0}}};

    state_t                  state;
    logic [DELAYWIDTH-1:0]   delay_lat;
    logic [DECIMWIDTH-1:0]   decim_lat;
    logic [ADDRWIDTH:0]      length_lat;
    logic [DELAYWIDTH-1:0]   dly_cnt;
    logic [DECIMWIDTH-1:0]   dec_cnt;
    logic [ADDRWIDTH-1:0]    ptr;

    logic [ADDRWIDTH:0]      length_clamped;
    logic [ADDRWIDTH:0]      wrcount_nxt;

    // Clamp the requested length and precompute the post-write count.
    always_comb begin
        length_clamped = (length > DEPTH) ? DEPTH : length;
        wrcount_nxt    = wrcount + (ADDRWIDTH+1)'(1);
    end

    // Sequencer state, configuration latches, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            delay_lat  <= '0;
            decim_lat  <= '0;
            length_lat <= '0;
            dly_cnt    <= '0;
            dec_cnt    <= '0;
            ptr        <= '0;
            bram_addr  <= '0;
            bram_data  <= '0;
            bram_we    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            wrcount    <= '0;
        end else begin
            bram_we <= 1'b0;
            if (abort) begin
                // Abort wins over arm, trig and a same-cycle sample.
                state <= S_IDLE;
                done  <= 1'b0;
                busy  <= 1'b0;
            end else begin
                case (state)
                    S_IDLE, S_DONE: begin
                        if (arm) begin
                            delay_lat  <= delay;
                            decim_lat  <= decim;
                            length_lat <= length_clamped;
                            wrcount    <= '0;
                            ptr        <= '0;
                            dec_cnt    <= '0;
                            if (length_clamped == '0) begin
                                state <= S_DONE;
                                done  <= 1'b1;
                                busy  <= 1'b0;
                            end else begin
                                state <= S_ARMED;
                                done  <= 1'b0;
                                busy  <= 1'b1;
                            end
                        end
                    end
                    S_ARMED: begin
                        if (trig) begin
                            if (delay_lat == '0) begin
                                state <= S_CAPTURE;
                            end else begin
                                dly_cnt <= delay_lat;
                                state   <= S_DELAY;
                            end
                        end
                    end
                    S_DELAY: begin
                        dly_cnt <= dly_cnt - DELAYWIDTH'(1);
                        if (dly_cnt == DELAYWIDTH'(1)) begin
                            state <= S_CAPTURE;
                        end
                    end
                    S_CAPTURE: begin
                        if (din_valid) begin
                            dec_cnt <= (dec_cnt == decim_lat) ? '0 : dec_cnt + DECIMWIDTH'(1);
                            if (dec_cnt == '0) begin
                                bram_we   <= 1'b1;
                                bram_addr <= ptr;
                                bram_data <= din;
                                ptr       <= ptr + ADDRWIDTH'(1);
                                wrcount   <= wrcount_nxt;
                                if (wrcount_nxt == length_lat) begin
                                    state <= S_DONE;
                                    done  <= 1'b1;
                                    busy  <= 1'b0;
                                end
                            end
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_adc_capture_seq.sv
// Scoreboard bench for adc_capture_seq: stimulus pushes the expected BRAM
// writes (address, data, cycle of appearance); a negedge monitor pops and
// compares every bram_we pulse and flags any unexpected write.
module tb_adc_capture_seq;

    localparam int AW = 4;
    localparam int DW = 32;
    localparam int LW = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic [LW-1:0] delay = '0;
    logic [CW-1:0] decim = '0;
    logic [AW:0]   length = '0;
    logic [DW-1:0] din;
    logic          din_valid = 1'b0;
    logic [AW-1:0] bram_addr;
    logic [DW-1:0] bram_data;
    logic          bram_we;
    logic          busy;
    logic          done;
    logic [AW:0]   wrcount;

    int cyc = 0;
    int n_total = 0;
    int n_pass = 0;

    typedef struct {
        int addr;
        int data;
        int cyc;
    } exp_t;

    exp_t exp_q[$];

    adc_capture_seq #(
        .ADDRWIDTH (AW),
        .DATAWIDTH (DW),
        .DELAYWIDTH(LW),
        .DECIMWIDTH(CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .arm      (arm),
        .abort    (abort),
        .trig     (trig),
        .delay    (delay),
        .decim    (decim),
        .length   (length),
        .din      (din),
        .din_valid(din_valid),
        .bram_addr(bram_addr),
        .bram_data(bram_data),
        .bram_we  (bram_we),
        .busy     (busy),
        .done     (done),
        .wrcount  (wrcount)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign din = DW'(cyc);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic push_write(input int addr, input int data, input int at_cyc);
        exp_t e;
        e.addr = addr;
        e.data = data;
        e.cyc  = at_cyc;
        exp_q.push_back(e);
    endtask

    task automatic do_arm(input int len, input int dly, input int dec);
        length = (AW+1)'(len);
        delay  = LW'(dly);
        decim  = CW'(dec);
        arm    = 1'b1;
        tick();
        arm    = 1'b0;
    endtask

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && bram_we) begin
            exp_t e;
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL spurious_write: addr %0d data %0d at cycle %0d, none expected",
                         bram_addr, bram_data, cyc);
            end else begin
                e = exp_q.pop_front();
                if (int'(bram_addr) == e.addr && bram_data == DW'(e.data) && cyc == e.cyc)
                    n_pass++;
                else
                    $display("FAIL write: got addr %0d data %0d cycle %0d expected addr %0d data %0d cycle %0d",
                             bram_addr, bram_data, cyc, e.addr, e.data, e.cyc);
            end
        end
    end

    initial begin
        int t;
        tick();
        tick();
        reset = 1'b0;
        check("rst_addr", bram_addr, 0);
        check("rst_data", bram_data, 0);
        check("rst_we", bram_we, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrcount", wrcount, 0);

        // Basic capture: length 4, no delay, no decimation.
        din_valid = 1'b1;
        do_arm(4, 0, 0);
        check("basic_busy_after_arm", busy, 1);
        t = cyc;
        for (int i = 0; i < 4; i++) push_write(i, t + 1 + i, t + 2 + i);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (3) tick();
        check("basic_done_early", done, 0);
        tick();
        check("basic_done", done, 1);
        check("basic_busy", busy, 0);
        check("basic_wrcount", wrcount, 4);

        // Delay 3, decimation 2, length 3.
        do_arm(3, 3, 2);
        t = cyc;
        push_write(0, t + 4, t + 5);
        push_write(1, t + 7, t + 8);
        push_write(2, t + 10, t + 11);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (10) tick();
        check("decim_done", done, 1);
        check("decim_wrcount", wrcount, 3);

        // Gapped valid: 1,0,0,1 in CAPTURE.
        do_arm(2, 0, 0);
        t = cyc;
        trig = 1'b1;
        tick();
        trig = 1'b0;
        din_valid = 1'b1;
        push_write(0, t + 1, t + 2);
        tick();
        din_valid = 1'b0;
        tick();
        tick();
        din_valid = 1'b1;
        push_write(1, t + 4, t + 5);
        tick();
        check("gap_done", done, 1);
        check("gap_wrcount", wrcount, 2);

        // length 0: straight to DONE with no writes.
        do_arm(0, 0, 0);
        check("len0_done", done, 1);
        check("len0_busy", busy, 0);
        check("len0_wrcount", wrcount, 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (4) tick();

        // Over-length request clamps to full depth.
        do_arm((1 << AW) + 1, 0, 0);
        t = cyc;
        for (int i = 0; i < (1 << AW); i++) push_write(i, t + 1 + i, t + 2 + i);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (16) tick();
        check("clamp_done", done, 1);
        check("clamp_wrcount", wrcount, 1 << AW);
        check("clamp_last_addr", bram_addr, (1 << AW) - 1);
        repeat (3) tick();

        // Abort after 2 writes, with an ignored arm during CAPTURE.
        do_arm(8, 0, 0);
        t = cyc;
        push_write(0, t + 1, t + 2);
        push_write(1, t + 2, t + 3);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        length = (AW+1)'(1);
        arm = 1'b1;
        tick();
        arm = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_wrcount", wrcount, 2);
        repeat (5) tick();

        // trig coincident with arm is not a trigger.
        length = (AW+1)'(1);
        delay = '0;
        decim = '0;
        arm = 1'b1;
        trig = 1'b1;
        tick();
        arm = 1'b0;
        trig = 1'b0;
        repeat (5) tick();
        check("armtrig_busy", busy, 1);
        check("armtrig_done", done, 0);
        t = cyc;
        push_write(0, t + 1, t + 2);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        check("armtrig_done_after", done, 1);
        check("armtrig_wrcount", wrcount, 1);

        // Reset during DELAY.
        do_arm(2, 10, 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rrst_addr", bram_addr, 0);
        check("rrst_data", bram_data, 0);
        check("rrst_we", bram_we, 0);
        check("rrst_busy", busy, 0);
        check("rrst_done", done, 0);
        check("rrst_wrcount", wrcount, 0);
        trig = 1'b1;
        tick();
        trig = 1'b0;
        repeat (15) tick();
        check("rrst_busy_late", busy, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
